// File: rtl/adc_frame_packer_if.sv
// FIFO-side bus of adc_frame_packer: the packed data word, the TLP header write port
// and the data-FIFO full flag. The packer drives the master modport and the FIFOs sit on slave.
interface adc_frame_packer_if;
    logic [63:0] TLPData;
    logic        DataWriteEnable;
    logic [39:0] TLPHeader;
    logic        HeaderWriteEnable;
    logic        DataFull;

    modport master (output TLPData, DataWriteEnable, TLPHeader, HeaderWriteEnable,
                    input  DataFull);
    modport slave  (input  TLPData, DataWriteEnable, TLPHeader, HeaderWriteEnable,
                    output DataFull);
endinterface

// File: rtl/adc_frame_packer.sv
// Packs ADC samples into 64-bit words grouped into frames and TLPs, emitting a header per TLP.
// Optional ADC_TEST_PATTERN_EN replaces every selected sample with a free-running counter.
module adc_frame_packer #(
    parameter int NUM_CH    = 2,
    parameter int SAMPLE_W  = 8,
    parameter int TLP_WORDS = 15
) (
    input  logic                       InputClock,
    input  logic                       rst_n,
    input  logic [NUM_CH*SAMPLE_W-1:0] i_AdcData,
    input  logic                       i_AdcValid,
    input  logic                       i_Enable,
    input  logic [12:0]                i_FrameLength,
    input  logic                       i_AutoSwitch,
    input  logic [NUM_CH-1:0]          i_ChannelMask,
    input  logic [1:0]                 i_SelectedChannel,
    input  logic [15:0]                i_BufferLengthTLPs,
    adc_frame_packer_if.master         fifo,
    output logic                       o_FrameStart,
    output logic                       o_Overflow,
    output logic [15:0]                o_DropCount
);
    localparam int SPW = 64 / SAMPLE_W;

    typedef enum logic [1:0] {IDLE, PACK, GAP} state_t;
    state_t r_state, w_nextState;

    logic [12:0]         r_frameLast;
    logic                r_autoSwitch;
    logic [NUM_CH-1:0]   r_chanMask;
    logic [3:0]          r_sampleCnt;
    logic [12:0]         r_wordCnt;
    logic [4:0]          r_tlpPos;
    logic [15:0]         r_tlpCounter, r_bufCounter;
    logic [1:0]          r_chan;
    logic [63:0]         r_word, r_tlpData;
    logic [39:0]         r_tlpHeader;
    logic                r_dataWe, r_headerWe, r_frameStart, r_overflow;
    logic [15:0]         r_dropCount;

    logic                w_accept, w_gapSample, w_enterPack, w_wordDone, w_lastWord;
    logic [12:0]         w_frameLast;
    logic [15:0]         w_tlpLast;
    logic [3:0]          w_maskNow, w_maskLatched;
    logic [1:0]          w_firstChan, w_stepChan, w_higherChan, w_manChan, w_chan;
    logic                w_hasHigher;
    logic [SAMPLE_W-1:0] w_sample, w_dataSample;
    logic [63:0]         w_wordNext;

    assign w_frameLast = (i_FrameLength == 13'd0) ? 13'd0 : i_FrameLength - 13'd1;
    assign w_tlpLast   = (i_BufferLengthTLPs == 16'd0) ? 16'd0 : i_BufferLengthTLPs - 16'd1;
    assign w_wordDone  = (r_sampleCnt == 4'(SPW - 1));
    assign w_lastWord  = (r_wordCnt == r_frameLast);
    assign w_manChan   = ({1'b0, i_SelectedChannel} < 3'(NUM_CH)) ? i_SelectedChannel : 2'd0;
    assign w_chan      = r_autoSwitch ? r_chan : w_manChan;

    // Rotation: lowest set bit starts a frame, then the next higher set bit with wrap-around.
    always_comb begin
        w_maskNow     = 4'(i_ChannelMask);
        w_maskLatched = 4'(r_chanMask);
        w_firstChan   = 2'd0;
        w_stepChan    = 2'd0;
        w_higherChan  = 2'd0;
        w_hasHigher   = 1'b0;
        for (int c = 3; c >= 0; c--) begin
            if (w_maskNow[c]) w_firstChan = 2'(c);
            if (w_maskLatched[c]) begin
                w_stepChan = 2'(c);
                if (2'(c) > r_chan) begin
                    w_higherChan = 2'(c);
                    w_hasHigher  = 1'b1;
                end
            end
        end
        if (w_hasHigher) w_stepChan = w_higherChan;
    end

    always_comb begin
        w_sample = i_AdcData[SAMPLE_W-1:0];
        for (int c = 0; c < NUM_CH; c++)
            if (w_chan == 2'(c)) w_sample = i_AdcData[c*SAMPLE_W +: SAMPLE_W];
    end

`ifdef ADC_TEST_PATTERN_EN
    logic [SAMPLE_W-1:0] r_pattern;

    always_ff @(posedge InputClock or negedge rst_n) begin
        if (!rst_n)          r_pattern <= '0;
        else if (i_AdcValid) r_pattern <= r_pattern + 1'b1;
    end

    assign w_dataSample = r_pattern;
`else
    assign w_dataSample = w_sample;
`endif

    // First sample of a word lands in the MSBs; the word restarts from zero so spare LSBs stay 0.
    always_comb begin
        w_wordNext = (r_sampleCnt == 4'd0) ? 64'd0 : r_word;
        for (int k = 0; k < SPW; k++)
            if (r_sampleCnt == 4'(k)) w_wordNext[63 - k*SAMPLE_W -: SAMPLE_W] = w_dataSample;
    end

    always_ff @(posedge InputClock or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Enable low wins over everything, so a word completing on that edge is simply lost.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_gapSample = 1'b0;
        w_enterPack = 1'b0;
        if (!i_Enable) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState = PACK;
                    w_enterPack = 1'b1;
                end
                PACK: begin
                    if (i_AdcValid) begin
                        w_accept = 1'b1;
                        if (w_wordDone && w_lastWord) w_nextState = GAP;
                    end
                end
                GAP: begin
                    if (i_AdcValid) begin
                        w_gapSample = 1'b1;
                        if (w_wordDone) begin
                            w_nextState = PACK;
                            w_enterPack = 1'b1;
                        end
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Datapath; the TLP position advances on dropped words too so framing never slips.
    always_ff @(posedge InputClock or negedge rst_n) begin
        if (!rst_n) begin
            r_frameLast  <= '0;
            r_autoSwitch <= 1'b0;
            r_chanMask   <= '0;
            r_sampleCnt  <= '0;
            r_wordCnt    <= '0;
            r_tlpPos     <= '0;
            r_tlpCounter <= '0;
            r_bufCounter <= '0;
            r_chan       <= '0;
            r_word       <= '0;
            r_tlpData    <= '0;
            r_tlpHeader  <= '0;
            r_dataWe     <= 1'b0;
            r_headerWe   <= 1'b0;
            r_frameStart <= 1'b0;
            r_overflow   <= 1'b0;
            r_dropCount  <= '0;
        end else begin
            r_dataWe     <= 1'b0;
            r_headerWe   <= 1'b0;
            r_frameStart <= w_enterPack;
            if (w_enterPack) begin
                r_frameLast  <= w_frameLast;
                r_autoSwitch <= i_AutoSwitch;
                r_chanMask   <= i_ChannelMask;
                r_chan       <= w_firstChan;
                r_sampleCnt  <= '0;
                r_wordCnt    <= '0;
            end else if (w_accept) begin
                r_chan <= w_stepChan;
                r_word <= w_wordNext;
                if (w_wordDone) begin
                    r_sampleCnt <= '0;
                    r_wordCnt   <= r_wordCnt + 13'd1;
                    if (!fifo.DataFull) begin
                        r_tlpData <= w_wordNext;
                        r_dataWe  <= 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                        if (r_dropCount != 16'hFFFF) r_dropCount <= r_dropCount + 16'd1;
                    end
                    if (r_tlpPos == 5'(TLP_WORDS - 1)) begin
                        r_tlpPos <= '0;
                        if (!fifo.DataFull) begin
                            r_tlpHeader <= {r_bufCounter, r_tlpCounter, i_SelectedChannel,
                                            r_autoSwitch, r_overflow, 4'b1111};
                            r_headerWe  <= 1'b1;
                        end
                        if (r_tlpCounter == w_tlpLast) begin
                            r_tlpCounter <= '0;
                            r_bufCounter <= r_bufCounter + 16'd1;
                        end else begin
                            r_tlpCounter <= r_tlpCounter + 16'd1;
                        end
                    end else begin
                        r_tlpPos <= r_tlpPos + 5'd1;
                    end
                end else begin
                    r_sampleCnt <= r_sampleCnt + 4'd1;
                end
            end else if (w_gapSample) begin
                r_sampleCnt <= r_sampleCnt + 4'd1;
            end
        end
    end

    assign fifo.TLPData           = r_tlpData;
    assign fifo.DataWriteEnable   = r_dataWe;
    assign fifo.TLPHeader         = r_tlpHeader;
    assign fifo.HeaderWriteEnable = r_headerWe;
    assign o_FrameStart           = r_frameStart;
    assign o_Overflow             = r_overflow;
    assign o_DropCount            = r_dropCount;
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: an 8-bit single-channel instance and a 12-bit
// two-channel instance share control inputs; expected values are hand-derived constants.
module tb_adc_frame_packer;
    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  adcDataA;
    logic [23:0] adcDataB;
    logic        adcValid, enable, autoSwitch, dataFull;
    logic [12:0] frameLength;
    logic [0:0]  maskA;
    logic [1:0]  maskB, selChan;
    logic [15:0] bufLen;
    logic        frameStartA, overflowA, frameStartB, overflowB;
    logic [15:0] dropCountA, dropCountB;
    int          checks = 0;
    int          errors = 0;

    adc_frame_packer_if busA();
    adc_frame_packer_if busB();

    assign busA.DataFull = dataFull;
    assign busB.DataFull = dataFull;

    adc_frame_packer #(.NUM_CH(1), .SAMPLE_W(8), .TLP_WORDS(15)) dutA (
        .InputClock(clk), .rst_n(rstN), .i_AdcData(adcDataA), .i_AdcValid(adcValid),
        .i_Enable(enable), .i_FrameLength(frameLength), .i_AutoSwitch(autoSwitch),
        .i_ChannelMask(maskA), .i_SelectedChannel(selChan), .i_BufferLengthTLPs(bufLen),
        .fifo(busA.master), .o_FrameStart(frameStartA), .o_Overflow(overflowA),
        .o_DropCount(dropCountA));

    adc_frame_packer #(.NUM_CH(2), .SAMPLE_W(12), .TLP_WORDS(2)) dutB (
        .InputClock(clk), .rst_n(rstN), .i_AdcData(adcDataB), .i_AdcValid(adcValid),
        .i_Enable(enable), .i_FrameLength(frameLength), .i_AutoSwitch(autoSwitch),
        .i_ChannelMask(maskB), .i_SelectedChannel(selChan), .i_BufferLengthTLPs(bufLen),
        .fifo(busB.master), .o_FrameStart(frameStartB), .o_Overflow(overflowB),
        .o_DropCount(dropCountB));

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // One clock with the given sample strobe; outputs are settled 1 unit after the edge
    task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [23:0] b);
        adcValid = valid;
        adcDataA = a;
        adcDataB = b;
        @(posedge clk);
        #1;
        adcValid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rstN = 1'b0;
        enable = 1'b0;
        dataFull = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // Linear sequence of directed steps
    initial begin
        logic [63:0] expWord;
        int          idx;
        rstN = 1'b0; adcDataA = '0; adcDataB = '0; adcValid = 1'b0; enable = 1'b0;
        autoSwitch = 1'b0; dataFull = 1'b0; frameLength = 13'd2; maskA = 1'b1;
        maskB = 2'b11; selChan = 2'd0; bufLen = 16'd2;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetTlpDataA", busA.TLPData, 64'd0);
        checkOutput("resetHeaderA", busA.TLPHeader, 40'd0);
        checkOutput("resetStrobesA", {busA.DataWriteEnable, busA.HeaderWriteEnable, frameStartA, overflowA}, 4'b0);
        checkOutput("resetDropA", dropCountA, 16'd0);
        checkOutput("resetOutputsB", {busB.TLPData, busB.DataWriteEnable, frameStartB, overflowB, dropCountB}, 83'd0);
        rstN = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);

        $display("[TB] Basic 8-bit packing with FrameLength=2");
        enable = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);
        checkOutput("firstFrameStart", frameStartA, 1'b1);
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(1'b1, 8'(i), 24'h0);
            checkOutput($sformatf("basicWe%0d", i), busA.DataWriteEnable, (i == 8 || i == 16));
            checkOutput($sformatf("basicFs%0d", i), frameStartA, (i == 24));
            if (i == 8)  checkOutput("basicWord0", busA.TLPData, 64'h0102030405060708);
            if (i == 16) checkOutput("basicWord1", busA.TLPData, 64'h090A0B0C0D0E0F10);
        end
        checkOutput("basicHold", busA.TLPData, 64'h090A0B0C0D0E0F10);

        $display("[TB] 12-bit two-channel rotation");
        doReset();
        autoSwitch = 1'b1; frameLength = 13'd4;
        enable = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);
        checkOutput("rotFrameStart", frameStartB, 1'b1);
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b1, 8'h00, {12'h200 + 12'(n), 12'h100 + 12'(n)});
            if (n == 4) begin
                checkOutput("rotWe0", busB.DataWriteEnable, 1'b1);
                checkOutput("rotWord0", busB.TLPData, 64'h1002011022031040);
            end
            if (n == 9) begin
                checkOutput("rotWord1", busB.TLPData, 64'h2051062071082090);
                checkOutput("rotHeaderWe", busB.HeaderWriteEnable, 1'b1);
                checkOutput("rotHeader", busB.TLPHeader, 40'h000000002F);
            end
        end

        $display("[TB] TLP headers over 60 words, BufferLengthTLPs=2");
        doReset();
        autoSwitch = 1'b0; frameLength = 13'd100; bufLen = 16'd2;
        enable = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);
        expWord = '0;
        for (int w = 0; w < 65; w++) begin
            for (int j = 0; j < 8; j++) begin
                applyStimulus(1'b1, 8'(8*w + j), 24'h0);
                expWord = {expWord[55:0], 8'(8*w + j)};
            end
            checkOutput($sformatf("tlpWe%0d", w), busA.DataWriteEnable, 1'b1);
            checkOutput($sformatf("tlpWord%0d", w), busA.TLPData, expWord);
            checkOutput($sformatf("tlpHwe%0d", w), busA.HeaderWriteEnable, (w % 15 == 14 && w < 60));
            if (w % 15 == 14 && w < 60) begin
                idx = w / 15;
                checkOutput($sformatf("tlpHeader%0d", idx), busA.TLPHeader,
                            {16'(idx / 2), 16'(idx % 2), 8'h0F});
            end
        end

        $display("[TB] Asynchronous reset mid-TLP");
        rstN = 1'b0;
        #1;
        checkOutput("midResetData", busA.TLPData, 64'd0);
        checkOutput("midResetHeader", busA.TLPHeader, 40'd0);
        checkOutput("midResetStrobes", {busA.DataWriteEnable, busA.HeaderWriteEnable, frameStartA, overflowA}, 4'b0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);
        checkOutput("postResetFs", frameStartA, 1'b1);
        for (int i = 0; i < 120; i++) applyStimulus(1'b1, 8'(i), 24'h0);
        checkOutput("postResetHwe", busA.HeaderWriteEnable, 1'b1);
        checkOutput("postResetHeader", busA.TLPHeader, 40'h000000000F);

        $display("[TB] DataFull for three word completions");
        doReset();
        frameLength = 13'd4;
        enable = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);
        for (int i = 1; i <= 48; i++) begin
            dataFull = (i == 16 || i == 24 || i == 32);
            applyStimulus(1'b1, 8'(i), 24'h0);
            checkOutput($sformatf("fullWe%0d", i), busA.DataWriteEnable, (i == 8 || i == 48));
            checkOutput($sformatf("fullFs%0d", i), frameStartA, (i == 40));
            checkOutput($sformatf("fullOvf%0d", i), overflowA, (i >= 16));
        end
        dataFull = 1'b0;
        checkOutput("fullDropCount", dropCountA, 16'd3);
        checkOutput("fullNextWord", busA.TLPData, 64'h292A2B2C2D2E2F30);

        $display("[TB] Enable dropped mid-word");
        doReset();
        enable = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 24'h0);
        enable = 1'b0;
        applyStimulus(1'b1, 8'hA4, 24'h0);
        checkOutput("dropNoWrite", {busA.DataWriteEnable, frameStartA}, 2'b00);
        applyStimulus(1'b0, 8'h00, 24'h0);
        enable = 1'b1;
        applyStimulus(1'b0, 8'h00, 24'h0);
        checkOutput("dropRestartFs", frameStartA, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8'hB0 + 8'(i), 24'h0);
            checkOutput($sformatf("dropWe%0d", i), busA.DataWriteEnable, (i == 8));
        end
        checkOutput("dropWord", busA.TLPData, 64'hB1B2B3B4B5B6B7B8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Parametrised successor to the current 8/12-bit ADC packer. Gathers ADC samples from up to four channels into 64-bit words, groups the words into TLPs and frames, and emits a 40-bit TLP header per TLP. Sits between the ADC capture registers and the PCIe data and header FIFOs. Runs on one clock with a sample-valid strobe, in place of the current double-clock phase trick.

## Interface
- NUM_CH, 2: ADC channel count, 1..4.
- SAMPLE_W, 8: sample width, 8..16.
  - Samples per word: SPW = 64/SAMPLE_W, integer division.
- TLP_WORDS, 15: 64-bit words per TLP, 2..16.
- InputClock  in  1  ADC clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- AdcData  in  NUM_CH*SAMPLE_W  channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
- AdcValid  in  1  one sample per channel present this cycle.
- Enable  in  1  capture enable.
- FrameLength  in  13  data words per frame; 0 is treated as 1.
- AutoSwitch  in  1  1: rotate channel per sample; 0: use SelectedChannel.
- ChannelMask  in  NUM_CH  channels in the rotation.
- SelectedChannel  in  2  manual channel; values ≥ NUM_CH map to 0.
- BufferLengthTLPs  in  16  TLPs per buffer; 0 is treated as 1.
- DataFull  in  1  data FIFO full.
- TLPData  out  64  packed word.
- DataWriteEnable  out  1  one-cycle write strobe.
- TLPHeader  out  40  header word.
- HeaderWriteEnable  out  1  one-cycle header strobe.
- FrameStart  out  1  one-cycle pulse at frame start.
- Overflow  out  1  sticky: a word was dropped.
- DropCount  out  16  dropped words, saturating.

## Operation
- States:
  - IDLE → PACK when Enable=1.
  - PACK → GAP after the FrameLength-th word of a frame.
  - GAP → PACK after SPW further AdcValid samples are discarded. This is the noise-blanking word period.
  - Any state → IDLE when Enable=0. Any partial word is discarded. TLP and buffer counters keep their values.
- On each entry to PACK:
  - FrameStart pulses.
  - FrameLength, AutoSwitch and ChannelMask are latched for the whole frame.
  - The word and sample counters clear.
- Packing:
  - Sample k (0..SPW-1) of a word goes to bits [63-k*SAMPLE_W -: SAMPLE_W], so the first sample lands in the MSBs.
  - Unused LSBs are 0.
- Channel selection:
  - AutoSwitch=1: step to the next set bit of the latched ChannelMask on each AdcValid, ascending, with wrap. The first sample of a frame uses the lowest set bit. A mask of 0 selects channel 0.
  - AutoSwitch=0: use SelectedChannel.
- Word completion happens on the AdcValid carrying sample SPW-1:
  - DataFull=0: TLPData is updated and DataWriteEnable pulses.
  - DataFull=1: the word is dropped, Overflow is set, and DropCount increments, saturating at 16'hFFFF.
  - The frame and TLP position counters advance either way, so framing stays aligned.
- TLP and buffer counters:
  - On the TLP_WORDS-th word of a TLP, the header is {BufferCounter, TLPCounter, SelectedChannel, AutoSwitch, Overflow, 4'b1111}. It uses the counter values before the increment.
  - HeaderWriteEnable pulses in the same cycle as DataWriteEnable. It is suppressed if that word was dropped.
  - TLPCounter then increments. When TLPCounter = BufferLengthTLPs-1 it wraps to 0 and BufferCounter increments.
  - BufferCounter and TLPCounter are 16-bit and wrap silently.
- TLP alignment across frames: the TLP word position does not reset at a frame boundary, so a TLP may span two frames.
- Overflow clears only on reset.

## Timing
- Reset values: TLPData=0, TLPHeader=0, DataWriteEnable=0, HeaderWriteEnable=0, FrameStart=0, Overflow=0, DropCount=0. State is IDLE and all counters are 0.
- Latency: the strobe and data are registered and appear one cycle after the completing AdcValid edge.
- TLPData holds its value until the next written word.
- DataFull is sampled in the same cycle as the completing AdcValid.
- Enable falling: the word in flight at that edge is discarded and no strobe is issued.
- Enable rising: FrameStart appears the next cycle. Samples are accepted from that cycle on.
- An AdcValid gap of any length stalls the packer without data loss.
- Reset asserted mid-frame returns the block to reset values immediately. No partial strobe is issued.

## Configuration
- ADC_TEST_PATTERN_EN defined: each selected sample is replaced by an internal SAMPLE_W-bit counter.
  - The counter increments per AdcValid, wraps, and resets to 0 on rst_n.
  - Framing, header and handshake behaviour are unchanged.
- Not defined: samples come from AdcData, and the counter logic is absent.

## Test plan
- SAMPLE_W=8, NUM_CH=1, FrameLength=2, channel 0 fed 0x01..0x18:
  - Words 0x0102030405060708 and 0x090A0B0C0D0E0F10 are written.
  - Samples 0x11..0x18 are discarded in GAP.
  - FrameStart pulses once per frame.
- SAMPLE_W=12, AutoSwitch=1, ChannelMask=2'b11:
  - A word holds ch0,ch1,ch0,ch1,ch0 samples.
  - Bits [3:0] of the word are 0.
- TLP_WORDS=15, BufferLengthTLPs=2, 60 words written:
  - Four headers with {Buffer,TLP} = {0,0},{0,1},{1,0},{1,1}.
  - Each header is coincident with the 15th, 30th, 45th and 60th DataWriteEnable.
- DataFull held high for 3 word completions:
  - No DataWriteEnable for those words.
  - DropCount=3 and Overflow=1.
  - The next frame starts at the same sample index as with DataFull=0.
- Enable dropped after 3 of 8 samples, then raised:
  - No write for the partial word.
  - FrameStart appears 1 cycle after Enable rises.
  - The first new word contains only post-enable samples.
- rst_n pulsed low mid-TLP: all outputs go to 0 immediately, and the first header after reset reads {0,0}.
